// File: rtl/simd_sat_stage.sv
// rtl/simd_sat_stage.sv - 2-stage SIMD saturation/result stage with sticky per-byte status.
// Define SIMD_SAT_CNT_EN to build the 16-bit saturating event counter; otherwise o_sat_count is 0.
module simd_sat_stage (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_sum,
    input  logic [1:0]  i_width,
    input  logic [3:0]  i_sat_enable,
    input  logic [3:0]  i_sat_sign,
    input  logic [3:0]  i_sat_last,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_result,
    output logic [1:0]  o_out_width,
    output logic [3:0]  o_sat_flags,
    output logic [3:0]  o_sat_sticky,
    input  logic        i_sticky_clr,
    output logic [15:0] o_sat_count
);

    logic        r_s1_valid;
    logic [31:0] r_s1_sum;
    logic [1:0]  r_s1_width;
    logic [3:0]  r_s1_en;
    logic [3:0]  r_s1_sign;
    logic [3:0]  r_s1_last;

    logic        r_s2_valid;
    logic [31:0] r_s2_result;
    logic [1:0]  r_s2_width;
    logic [3:0]  r_s2_flags;
    logic [3:0]  r_sat_sticky;

    logic        w_s2_adv;
    logic        w_xfer;
    logic [31:0] w_s2_result;

    assign w_s2_adv   = !r_s2_valid || i_out_ready;
    assign o_in_ready = !r_s1_valid || w_s2_adv;
    assign w_xfer     = r_s2_valid && i_out_ready;

    // Saturated byte: MSB is the sign for the element's top byte, all others fill with ~sign.
    always_comb begin
        w_s2_result = r_s1_sum;
        for (int i = 0; i < 4; i++) begin
            if (r_s1_en[i]) begin
                w_s2_result[8*i +: 8] = {(r_s1_last[i] ? r_s1_sign[i] : ~r_s1_sign[i]),
                                         {7{~r_s1_sign[i]}}};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= 32'd0;
            r_s1_width <= 2'd0;
            r_s1_en    <= 4'd0;
            r_s1_sign  <= 4'd0;
            r_s1_last  <= 4'd0;
        end else if (o_in_ready) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_sum   <= i_sum;
                r_s1_width <= i_width;
                r_s1_en    <= i_sat_enable;
                r_s1_sign  <= i_sat_sign;
                r_s1_last  <= i_sat_last;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= 32'd0;
            r_s2_width  <= 2'd0;
            r_s2_flags  <= 4'd0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_s2_result;
                r_s2_width  <= r_s1_width;
                r_s2_flags  <= r_s1_en;
            end
        end
    end

    // A clear coinciding with a delivery keeps that delivery's flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sat_sticky <= 4'd0;
        end else if (i_sticky_clr) begin
            r_sat_sticky <= w_xfer ? r_s2_flags : 4'd0;
        end else if (w_xfer) begin
            r_sat_sticky <= r_sat_sticky | r_s2_flags;
        end
    end

`ifdef SIMD_SAT_CNT_EN
    logic [15:0] r_sat_count;
    logic        w_event;

    assign w_event = w_xfer && (r_s2_flags != 4'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sat_count <= 16'd0;
        end else if (i_sticky_clr) begin
            r_sat_count <= w_event ? 16'd1 : 16'd0;
        end else if (w_event && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign o_sat_count = r_sat_count;
`else
    assign o_sat_count = 16'd0;
`endif

    assign o_out_valid  = r_s2_valid;
    assign o_result     = r_s2_result;
    assign o_out_width  = r_s2_width;
    assign o_sat_flags  = r_s2_flags;
    assign o_sat_sticky = r_sat_sticky;

endmodule

// File: tb/tb_simd_sat_stage.sv
// tb/tb_simd_sat_stage.sv - scoreboard bench for simd_sat_stage with randomized traffic.
module tb_simd_sat_stage;

`ifdef SIMD_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_sum;
    logic [1:0]  i_width;
    logic [3:0]  i_sat_enable;
    logic [3:0]  i_sat_sign;
    logic [3:0]  i_sat_last;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_result;
    logic [1:0]  o_out_width;
    logic [3:0]  o_sat_flags;
    logic [3:0]  o_sat_sticky;
    logic        i_sticky_clr;
    logic [15:0] o_sat_count;

    simd_sat_stage dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_sum        (i_sum),
        .i_width      (i_width),
        .i_sat_enable (i_sat_enable),
        .i_sat_sign   (i_sat_sign),
        .i_sat_last   (i_sat_last),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_result     (o_result),
        .o_out_width  (o_out_width),
        .o_sat_flags  (o_sat_flags),
        .o_sat_sticky (o_sat_sticky),
        .i_sticky_clr (i_sticky_clr),
        .o_sat_count  (o_sat_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] r;
        logic [1:0]  w;
        logic [3:0]  f;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          rnd_ready = 1'b0;
    logic [3:0]  m_sticky = 4'd0;
    int          m_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] s, input logic [3:0] en,
                                               input logic [3:0] sg, input logic [3:0] ls);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                if (ls[i]) r[8*i +: 8] = sg[i] ? 8'h80 : 8'h7F;
                else       r[8*i +: 8] = sg[i] ? 8'h00 : 8'hFF;
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
        if (rnd_ready) begin
            i_out_ready  = ($urandom_range(0, 3) != 0);
            i_sticky_clr = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic send(input logic [31:0] s, input logic [1:0] w, input logic [3:0] en,
                        input logic [3:0] sg, input logic [3:0] ls);
        bit acc;
        acc = 1'b0;
        i_in_valid = 1'b1; i_sum = s; i_width = w;
        i_sat_enable = en; i_sat_sign = sg; i_sat_last = ls;
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            if (o_in_ready) begin
                q.push_back('{r: ref_result(s, en, sg, ls), w: w, f: en});
                acc = 1'b1;
            end
            step();
            if (acc) break;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        i_in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [31:0] exp);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge i_clk);
            if (o_out_valid) begin
                check(name, o_result, exp);
                seen = 1'b1;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && q.size() != 0; t++) begin
            @(posedge i_clk);
            #1;
        end
        check("drain_empty", q.size(), 0);
    endtask

    // Monitor: compares delivered payloads against the queue and tracks expected status.
    always @(negedge i_clk) begin
        exp_t       e;
        logic       xf;
        logic [3:0] ef;
        if (!i_rst_n) begin
            m_sticky = 4'd0;
            m_count  = 0;
            check("rst_out_valid", o_out_valid, 0);
            check("rst_sticky", o_sat_sticky, 0);
        end else begin
            xf = 1'b0;
            ef = 4'd0;
            check("sticky", o_sat_sticky, m_sticky);
            check("count", o_sat_count, m_count);
            if (o_out_valid && !i_out_ready && q.size() != 0)
                check("stall_payload", o_result, q[0].r);
            if (o_out_valid && i_out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", o_result, 32'hDEAD_BEEF);
                end else begin
                    e = q.pop_front();
                    check("result", o_result, e.r);
                    check("out_width", o_out_width, e.w);
                    check("sat_flags", o_sat_flags, e.f);
                    xf = 1'b1;
                    ef = e.f;
                end
            end
            if (i_sticky_clr) begin
                m_sticky = xf ? ef : 4'd0;
                m_count  = (xf && ef != 0) ? 1 : 0;
            end else if (xf) begin
                m_sticky = m_sticky | ef;
                if (ef != 0 && m_count != 16'hFFFF) m_count++;
            end
            if (!CNT_EN) m_count = 0;
        end
    end

    logic [31:0] bp_sum [4];
    logic [3:0]  bp_en  [4];

    initial begin
        int  k;
        bit  rdy;
        i_rst_n = 1'b0; i_in_valid = 1'b0; i_sum = '0; i_width = '0;
        i_sat_enable = '0; i_sat_sign = '0; i_sat_last = '0;
        i_out_ready = 1'b0; i_sticky_clr = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("reset_in_ready", o_in_ready, 1);
        check("reset_result", o_result, 0);
        check("reset_width", o_out_width, 0);
        check("reset_flags", o_sat_flags, 0);
        step();

        // 32-bit positive saturation with latency check
        i_out_ready = 1'b1;
        send(32'h8000_0001, 2'b10, 4'b1111, 4'b0000, 4'b1000);
        @(negedge i_clk);
        check("lat_cycle1_valid", o_out_valid, 0);
        @(negedge i_clk);
        check("lat_cycle2_valid", o_out_valid, 1);
        check("t1_result", o_result, 32'h7FFF_FFFF);
        check("t1_flags", o_sat_flags, 4'b1111);
        step();
        i_sticky_clr = 1'b1;
        step();
        i_sticky_clr = 1'b0;

        // 16-bit mixed
        send(32'h1234_5678, 2'b01, 4'b1100, 4'b1100, 4'b1010);
        wait_out("t2_result", 32'h8000_5678);
        @(negedge i_clk);
        check("t2_sticky", o_sat_sticky, 4'b1100);
        step();

        // 8-bit lanes
        send(32'hAABB_CCDD, 2'b00, 4'b0101, 4'b0001, 4'b1111);
        wait_out("t3_result", 32'hAA7F_CC80);
        @(negedge i_clk);
        check("t3_count", o_sat_count, CNT_EN ? 2 : 0);
        check("t3_sticky", o_sat_sticky, 4'b1101);
        step();

        // Back-pressure: out_ready low for 3 cycles while streaming 4
        for (int i = 0; i < 4; i++) begin
            bp_sum[i] = $urandom;
            bp_en[i]  = 4'($urandom);
        end
        i_out_ready = 1'b0;
        k = 0;
        i_in_valid = 1'b1; i_sum = bp_sum[0]; i_width = 2'b00;
        i_sat_enable = bp_en[0]; i_sat_sign = 4'b0101; i_sat_last = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            rdy = o_in_ready;
            check("bp_in_ready", rdy, (c < 2) ? 1 : 0);
            if (rdy) begin
                q.push_back('{r: ref_result(bp_sum[k], bp_en[k], 4'b0101, 4'b1111),
                              w: 2'b00, f: bp_en[k]});
                k++;
            end
            step();
            i_sum = bp_sum[k]; i_sat_enable = bp_en[k];
        end
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        while (k < 4) begin
            send(bp_sum[k], 2'b00, bp_en[k], 4'b0101, 4'b1111);
            k++;
        end
        drain();

        // Clear coinciding with a saturating delivery
        i_out_ready = 1'b0;
        send(32'h1122_3344, 2'b00, 4'b0010, 4'b0000, 4'b0000);
        for (int t = 0; t < 20; t++) begin
            @(negedge i_clk);
            if (o_out_valid) break;
        end
        step();
        i_sticky_clr = 1'b1;
        i_out_ready  = 1'b1;
        step();
        i_sticky_clr = 1'b0;
        @(negedge i_clk);
        check("clr_xfer_sticky", o_sat_sticky, 4'b0010);
        check("clr_xfer_count", o_sat_count, CNT_EN ? 1 : 0);
        step();

`ifdef SIMD_SAT_CNT_EN
        for (int i = 0; i < 65536; i++)
            send($urandom, 2'b00, 4'b0001, 4'b0000, 4'b0001);
        drain();
        @(negedge i_clk);
        check("count_saturates", o_sat_count, 16'hFFFF);
        step();
`endif

        // Randomized traffic with random back-pressure and clears
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) step();
            else send($urandom, 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        rnd_ready = 1'b0;
        i_sticky_clr = 1'b0;
        i_out_ready = 1'b1;
        drain();

        // Reset with two transactions in flight
        i_out_ready = 1'b0;
        send(32'hCAFE_F00D, 2'b00, 4'b1111, 4'b0000, 4'b1111);
        send(32'h0BAD_0BAD, 2'b01, 4'b0011, 4'b0011, 4'b0010);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_out_valid", o_out_valid, 0);
        check("midrst_sticky", o_sat_sticky, 0);
        check("midrst_count", o_sat_count, 0);
        check("midrst_result", o_result, 0);
        q.delete();
        repeat (2) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        i_out_ready = 1'b1;
        repeat (6) begin
            @(negedge i_clk);
            check("post_rst_no_output", o_out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simd_sat_stage.md
# simd_sat_stage

Pipelined saturation/result stage of the packed-SIMD adder datapath. It sits directly downstream of the SIMD control block and consumes the raw 32-bit lane sum together with that block's per-byte `sat_enable`, `sat_sign` and `sat_last` vectors. It replaces saturated lanes with the lane's min/max value, registers the result through a 2-stage valid/ready pipeline, and keeps sticky per-byte saturation status plus an optional saturation-event counter.

## Interface
- No parameters; datapath is fixed at 32 bits, 4 byte lanes.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: upstream transaction valid.
- `in_ready` output 1: stage can accept a transaction this cycle.
- `sum` input 32: raw wrapped adder result, byte lane i = `sum[8i+7:8i]`.
- `width` input 2: 00 = 4×8, 01 = 2×16, 10 = 1×32, 11 = reserved (passed through).
- `sat_enable` input 4: byte lane i is replaced by its saturation value.
- `sat_sign` input 4: 1 = saturate toward most-negative, 0 = toward most-positive.
- `sat_last` input 4: 1 = byte lane i is the most-significant byte of its element.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts result.
- `result` output 32: saturated result.
- `out_width` output 2: `width` carried with the transaction.
- `sat_flags` output 4: `sat_enable` carried with the transaction.
- `sat_sticky` output 4: OR of `sat_flags` over all delivered transactions since last clear.
- `sticky_clr` input 1: synchronous clear of `sat_sticky` and `sat_count`.
- `sat_count` output 16: number of delivered transactions with any lane saturated.

## Operation
- Handshake on both ports: transfer when valid && ready. Valid never drops without a transfer; payload is stable while valid && !ready.
- Stage 1 (S1) registers `sum`, `width`, `sat_enable`, `sat_sign`, `sat_last`.
- Stage 2 (S2) registers the computed byte lanes: if `sat_enable[i]`=0, byte = sum byte; otherwise byte = {`sat_last[i]` ? ~`sat_sign[i]` : ~`sat_sign[i]`, 7×~`sat_sign[i]`} with the MSB of a `sat_last` byte inverted, i.e.:
  - `sat_last`=1, `sat_sign`=0 -> 0x7F; `sat_last`=1, `sat_sign`=1 -> 0x80.
  - `sat_last`=0, `sat_sign`=0 -> 0xFF; `sat_last`=0, `sat_sign`=1 -> 0x00.
- Lane masks are not checked against `width`; the stage trusts the upstream vectors.
- Stall: S2 advances when !S2.valid || `out_ready`; S1 advances into S2 when S2 advances; `in_ready` = !S1.valid || S1 advances. Full throughput at 1 transaction/cycle.
- Status updates on the output transfer (`out_valid && out_ready`):
  - `sat_sticky` |= `sat_flags`.
  - `sat_count` += 1 if `sat_flags` != 0; holds at 0xFFFF (no wrap).
- `sticky_clr` with a simultaneous saturating output transfer: cleared value is replaced by the new event (`sat_sticky` = `sat_flags`, `sat_count` = 1).

## Timing
- Latency: 2 cycles from input transfer to `out_valid` with no back-pressure.
- `in_ready` depends combinationally on `out_ready`; every other output is registered.
- Reset: `out_valid`=0, S1.valid=0, `result`=0, `out_width`=0, `sat_flags`=0, `sat_sticky`=0, `sat_count`=0; `in_ready`=1 while reset is deasserted and the pipe is empty.
- Reset asserted mid-operation drops all in-flight transactions immediately; nothing is delivered after release.
- Reserved `width`=11 is processed exactly like any other width, using the mask vectors.

## Configuration
- `SIMD_SAT_CNT_EN` defined: the 16-bit `sat_count` register is built as specified above.
- `SIMD_SAT_CNT_EN` not defined: no counter logic is built; `sat_count` is tied to 0. `sat_sticky` and the datapath are unchanged.

## Test plan
- 32-bit positive saturation: `sum`=0x8000_0001, `sat_enable`=1111, `sat_sign`=0000, `sat_last`=1000 -> `result`=0x7FFF_FFFF, `sat_flags`=1111, 2 cycles after input.
- 16-bit mixed: `sum`=0x1234_5678, `sat_enable`=1100, `sat_sign`=1100, `sat_last`=1010 -> `result`=0x8000_5678, `sat_sticky`=1100.
- 8-bit lanes: `sum`=0xAABB_CCDD, `sat_enable`=0101, `sat_sign`=0001, `sat_last`=1111 -> `result`=0xAA7F_CC80, `sat_count` +1.
- Back-pressure: stream 4 transactions with `out_ready`=0 for 3 cycles -> `in_ready` falls after 2 accepted, all 4 delivered in order with payload stable while stalled.
- `sticky_clr` with a simultaneous saturating transfer (`sat_flags`=0010) -> `sat_sticky`=0010, `sat_count`=1; counter preloaded to 0xFFFF plus one more event -> stays 0xFFFF.
- Assert `rst_n` low with 2 transactions in flight -> `out_valid`=0 and all status is 0 immediately; after release nothing is delivered.
